// File: rtl/keypad_emulator_pkg.sv
// Shared keypad definitions: emulator state encoding, timer commands,
// matrix dimensions and the key-code to row/column mapping.
package keypad_pkg;

    localparam int unsigned KP_ROWS = 4;
    localparam int unsigned KP_COLS = 4;
    localparam int unsigned KP_CODE_W = $clog2(KP_ROWS * KP_COLS);
    localparam logic [KP_COLS-1:0] COLS_IDLE = '1;

    typedef enum logic [2:0] {
        IDLE,
        BOUNCE_IN,
        HOLD,
        BOUNCE_OUT,
        GAP
    } kp_emu_state_t;

    typedef enum logic [1:0] {
        TMR_RUN,
        TMR_LOAD,
        TMR_NEXT
    } kp_tmr_cmd_t;

    function automatic logic [1:0] kc_row(input logic [KP_CODE_W-1:0] code);
        return code[3:2];
    endfunction

    function automatic logic [1:0] kc_col(input logic [KP_CODE_W-1:0] code);
        return code[1:0];
    endfunction

endpackage

// File: rtl/keypad_emulator_if.sv
// Key-press request handshake between a stimulus source and the emulator.
interface keypad_emulator_if;
    import keypad_pkg::*;

    logic                 key_valid;
    logic [KP_CODE_W-1:0] key_code;
    logic                 busy;
    logic                 done;

    modport master (output key_valid, key_code, input busy, done);
    modport slave  (input key_valid, key_code, output busy, done);

endinterface

// File: rtl/keypad_emulator_phase_timer.sv
// Down-counter with a phase index. LOAD restarts at phase 0, NEXT advances
// the phase and reloads, RUN counts down and parks at zero.
module phase_timer
    import keypad_pkg::*;
#(
    parameter int unsigned CW = 4,
    parameter int unsigned PW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  kp_tmr_cmd_t   cmd,
    input  logic [CW-1:0] load_val,
    output logic          expired,
    output logic [PW-1:0] phase,
    output logic          phase_next_lsb
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] phase_q, phase_d;

    // Next count and phase from the command issued this cycle.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        case (cmd)
            TMR_LOAD: begin
                cnt_d   = load_val;
                phase_d = '0;
            end
            TMR_NEXT: begin
                cnt_d   = load_val;
                phase_d = phase_q + PW'(1);
            end
            default: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
        endcase
    end

    // Counter and phase registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            phase_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign expired        = (cnt_q == '0);
    assign phase          = phase_q;
    assign phase_next_lsb = phase_d[0];

endmodule

// File: rtl/keypad_emulator.sv
// One 4x4 keypad switch emulated: closes the requested row/column contact
// with scripted bounce, holds it, releases with bounce, then pulses done.
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int unsigned BOUNCE_EDGES  = 4,
    parameter int unsigned BOUNCE_CYCLES = 8,
    parameter int unsigned HOLD_CYCLES   = 1000,
    parameter int unsigned GAP_CYCLES    = 100
) (
    input  logic               clk,
    input  logic               reset,
    keypad_emulator_if.slave   kp,
    input  logic [KP_ROWS-1:0] rows,
    output logic [KP_COLS-1:0] cols
);

    localparam int unsigned MAX_BH = (BOUNCE_CYCLES > HOLD_CYCLES) ? BOUNCE_CYCLES : HOLD_CYCLES;
    localparam int unsigned MAX_C  = (MAX_BH > GAP_CYCLES) ? MAX_BH : GAP_CYCLES;
    localparam int unsigned CW     = (MAX_C > 1) ? $clog2(MAX_C) : 1;
    localparam int unsigned PW     = (BOUNCE_EDGES > 0) ? $clog2(BOUNCE_EDGES + 1) : 1;
    localparam bit          HAS_BOUNCE = (BOUNCE_EDGES != 0);

    localparam logic [CW-1:0] BC_LOAD    = CW'(BOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_CYCLES - 1);
    localparam logic [PW-1:0] LAST_PHASE = PW'(BOUNCE_EDGES - 1);

    kp_emu_state_t state_q, state_d;
    logic [1:0]    row_q, row_d;
    logic [1:0]    col_q, col_d;
    logic          closed_q, closed_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    kp_tmr_cmd_t   tmr_cmd;
    logic [CW-1:0] tmr_load;
    logic          tmr_expired;
    logic [PW-1:0] tmr_phase;
    logic          tmr_phase_next_lsb;

    phase_timer #(
        .CW (CW),
        .PW (PW)
    ) u_timer (
        .clk            (clk),
        .reset          (reset),
        .cmd            (tmr_cmd),
        .load_val       (tmr_load),
        .expired        (tmr_expired),
        .phase          (tmr_phase),
        .phase_next_lsb (tmr_phase_next_lsb)
    );

    // Sequencer: state transitions, timer reloads and next-cycle outputs.
    // Contact level is derived from the next state/phase so it is registered
    // in step with the state change.
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        done_d   = 1'b0;
        tmr_cmd  = TMR_RUN;
        tmr_load = '0;
        case (state_q)
            IDLE: begin
                if (kp.key_valid) begin
                    row_d   = kc_row(kp.key_code);
                    col_d   = kc_col(kp.key_code);
                    tmr_cmd = TMR_LOAD;
                    if (HAS_BOUNCE) begin
                        state_d  = BOUNCE_IN;
                        tmr_load = BC_LOAD;
                    end else begin
                        state_d  = HOLD;
                        tmr_load = HOLD_LOAD;
                    end
                end
            end
            BOUNCE_IN: begin
                if (tmr_expired) begin
                    if (tmr_phase == LAST_PHASE) begin
                        state_d  = HOLD;
                        tmr_cmd  = TMR_LOAD;
                        tmr_load = HOLD_LOAD;
                    end else begin
                        tmr_cmd  = TMR_NEXT;
                        tmr_load = BC_LOAD;
                    end
                end
            end
            HOLD: begin
                if (tmr_expired) begin
                    tmr_cmd = TMR_LOAD;
                    if (HAS_BOUNCE) begin
                        state_d  = BOUNCE_OUT;
                        tmr_load = BC_LOAD;
                    end else begin
                        state_d  = GAP;
                        tmr_load = GAP_LOAD;
                    end
                end
            end
            BOUNCE_OUT: begin
                if (tmr_expired) begin
                    if (tmr_phase == LAST_PHASE) begin
                        state_d  = GAP;
                        tmr_cmd  = TMR_LOAD;
                        tmr_load = GAP_LOAD;
                    end else begin
                        tmr_cmd  = TMR_NEXT;
                        tmr_load = BC_LOAD;
                    end
                end
            end
            GAP: begin
                if (tmr_expired) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        case (state_d)
            BOUNCE_IN:  closed_d = ~tmr_phase_next_lsb;
            HOLD:       closed_d = 1'b1;
            BOUNCE_OUT: closed_d = tmr_phase_next_lsb;
            default:    closed_d = 1'b0;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            row_q    <= '0;
            col_q    <= '0;
            closed_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            closed_q <= closed_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Switch contact: unclocked path from the scanner's row drive.
    always_comb begin
        cols = COLS_IDLE;
        if (closed_q && !rows[row_q]) begin
            cols[col_q] = 1'b0;
        end
    end

    assign kp.busy = busy_q;
    assign kp.done = done_q;

endmodule
